mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller: producer side of the MEM/WB latch. Takes the EX/MEM
//  payload, issues one data-cache request per load/store, holds it until dhit,
//  captures load data, drives the MEM/WB *_in fields and the latch enable, and
//  stalls upstream stages while an access is outstanding. Sits between EX/MEM and MEM/WB.
// PARAMETERS
//  MAX_WAIT  255  saturation value of wait counter / access_lat (must fit 8 bits)
// PORTS
//  CLK          in   1   system clock, rising edge
//  nRST         in   1   asynchronous active-low reset
//  valid        in   1   EX/MEM slot holds a real instruction
//  MEMctrl      in   2   [1]=load, [0]=store
//  aluout       in   32  effective address / ALU result
//  storedata    in   32  store data
//  npc, imm, dest, WBctrl in 32/16/5/4  pass-through payload
//  ihit         in   1   instruction fetch complete (pipeline advance qualifier)
//  dhit         in   1   data access complete (1-cycle pulse)
//  dmemload     in   32  load data, valid when dhit=1
//  dmemREN      out  1   data read request
//  dmemWEN      out  1   data write request
//  dmemaddr     out  32  = aluout
//  dmemstore    out  32  = storedata
//  dmemload_in, aluout_in, npc_in out 32; imm_in 16; dest_in 5; WBctrl_in 4 -> MEM/WB
//  memwb_en     out  1   MEM/WB latch enable
//  mem_stall    out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  access_lat   out  8   cycles waited by last completed access, saturating
// BEHAVIOUR
//  - memop = valid & (MEMctrl!=0). MEMctrl=2'b11 is illegal: store wins, no read issued.
//  - States: IDLE, ACCESS, HOLD. Reset (async, nRST=0) -> IDLE, ldreg=0,
//    wait_cnt=0, access_lat=0; dmemREN=dmemWEN=mem_stall=memwb_en=0 while nRST=0.
//  - dmemREN/dmemWEN = MEMctrl bits, asserted only in IDLE/ACCESS with memop; 0 in HOLD.
//  - IDLE: memop & dhit -> capture; ihit ? IDLE : HOLD. memop & ~dhit -> ACCESS.
//    ~memop -> stay IDLE (pure pass-through).
//  - ACCESS: request held stable, wait_cnt++ (saturate MAX_WAIT). dhit -> ldreg<=dmemload,
//    access_lat<=wait_cnt+1 (saturated), wait_cnt<=0; ihit ? IDLE : HOLD.
//  - HOLD: no request (prevents duplicate store); wait for ihit -> IDLE.
//  - IDLE same-cycle dhit: access_lat<=0.
//  - mem_stall = memop & ~dhit & (state IDLE|ACCESS). Combinational.
//  - memwb_en = ihit & ~mem_stall. Latency: zero-wait hit advances same cycle.
//  - dmemload_in = dhit ? dmemload : ldreg (bypass on hit cycle); for non-loads
//    the value is don't-care downstream (WBctrl selects).
//  - aluout_in/npc_in/imm_in/dest_in/WBctrl_in: combinational pass-through.
//  - Invalid slot (valid=0): no request, WBctrl_in forced 4'b0 (bubble).
//  - Reset mid-ACCESS: request drops immediately, no capture, back to IDLE.
//  - Exactly one dhit consumed per instruction; dhit in HOLD/non-memop ignored.
// TESTING
//  1 Reset: nRST=0 mid-ACCESS -> dmemREN=0, mem_stall=0, access_lat=0 same cycle.
//  2 Load aluout=0x100, dhit after 3 cycles, dmemload=0xDEADBEEF, ihit=1 -> mem_stall
//    high 3 cycles, memwb_en pulses on dhit cycle, dmemload_in=0xDEADBEEF, access_lat=3.
//  3 Store, dhit cycle 2, ihit low 4 more cycles -> exactly one dmemWEN window,
//    HOLD with WEN=0 until ihit, then memwb_en=1.
//  4 Load, dhit same cycle as request, ihit=0 then 1 -> HOLD; dmemload_in=ldreg
//    value on advance cycle; access_lat=0.
//  5 dhit held off 300 cycles -> access_lat saturates at 255.
//  6 MEMctrl=2'b11 -> dmemWEN=1, dmemREN=0; valid=0 -> no request, WBctrl_in=0.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues one data-cache request per load/store, holds it
// until dhit, captures load data and drives the MEM/WB latch fields and enable.
//
//  state  | meaning
//  IDLE   | no access outstanding; new memop requests here, same-cycle hit allowed
//  ACCESS | request held stable waiting for dhit, wait counter running
//  HOLD   | access done, no request, waiting for ihit to advance the pipeline
module mem_stage_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        valid_i,
   input  logic [1:0]  memctrl_i,
   input  logic [31:0] aluout_i,
   input  logic [31:0] storedata_i,
   input  logic [31:0] npc_i,
   input  logic [15:0] imm_i,
   input  logic [4:0]  dest_i,
   input  logic [3:0]  wbctrl_i,
   input  logic        ihit_i,
   input  logic        dhit_i,
   input  logic [31:0] dmemload_i,
   output logic        dmem_ren_o,
   output logic        dmem_wen_o,
   output logic [31:0] dmemaddr_o,
   output logic [31:0] dmemstore_o,
   output logic [31:0] dmemload_in_o,
   output logic [31:0] aluout_in_o,
   output logic [31:0] npc_in_o,
   output logic [15:0] imm_in_o,
   output logic [4:0]  dest_in_o,
   output logic [3:0]  wbctrl_in_o,
   output logic        memwb_en_o,
   output logic        mem_stall_o,
   output logic [7:0]  access_lat_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  access_lat_q, access_lat_d;
   logic [31:0] ldreg_q, ldreg_d;

   logic       memop;
   logic       req_phase;
   logic       req_active;
   logic       hit_take;
   logic       stall;
   logic [7:0] lat_next;
   logic [7:0] wait_inc;

   assign memop      = valid_i & (memctrl_i != 2'b00);
   assign req_phase  = (state_q == IDLE) | (state_q == ACCESS);
   // Gating with reset makes the request drop in the same cycle reset asserts.
   assign req_active = rst_n_i & memop & req_phase;
   assign hit_take   = memop & req_phase & dhit_i;
   assign stall      = req_active & ~dhit_i;
   assign lat_next   = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 8'd1;
   assign wait_inc   = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 8'd1;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         wait_cnt_q   <= 8'd0;
         access_lat_q <= 8'd0;
         ldreg_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         access_lat_q <= access_lat_d;
         ldreg_q      <= ldreg_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      access_lat_d = access_lat_q;
      ldreg_d      = ldreg_q;
      case (state_q)
         IDLE: begin
            wait_cnt_d = 8'd0;
            if (hit_take) begin
               ldreg_d      = dmemload_i;
               access_lat_d = 8'd0;
               state_d      = ihit_i ? IDLE : HOLD;
            end else if (memop) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!memop) begin
               wait_cnt_d = 8'd0;
               state_d    = IDLE;
            end else if (hit_take) begin
               ldreg_d      = dmemload_i;
               access_lat_d = lat_next;
               wait_cnt_d   = 8'd0;
               state_d      = ihit_i ? IDLE : HOLD;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         HOLD: begin
            if (ihit_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dmem_ren_o    = req_active & memctrl_i[1] & ~memctrl_i[0];
      dmem_wen_o    = req_active & memctrl_i[0];
      mem_stall_o   = stall;
      memwb_en_o    = rst_n_i & ihit_i & ~stall;
      dmemaddr_o    = aluout_i;
      dmemstore_o   = storedata_i;
      dmemload_in_o = dhit_i ? dmemload_i : ldreg_q;
      aluout_in_o   = aluout_i;
      npc_in_o      = npc_i;
      imm_in_o      = imm_i;
      dest_in_o     = dest_i;
      wbctrl_in_o   = valid_i ? wbctrl_i : 4'b0000;
      access_lat_o  = access_lat_q;
   end

endmodule
